btn_debounce: RTL and testbench
===============================

BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 SHALL have parameter NUM_INPUTS, default 2: number of independent button channels.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 65536: consecutive stable cycles required before accepting a change; legal range 2..2^24.
REQ-003 SHALL have parameter ACTIVE_LOW, default 1: 1 = raw pin reads 0 when pressed (board buttons); the pin is inverted before the synchroniser.
REQ-004 SHALL have port clk, input, 1: single system clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port btn_raw_i, input, NUM_INPUTS: asynchronous raw button pins.
REQ-007 SHALL have port clr_i, input, NUM_INPUTS: per-channel clear of the sticky press flag.
REQ-008 SHALL have port btn_o, output, NUM_INPUTS: debounced level, 1 = pressed; drives the SoC gpio_i bits.
REQ-009 SHALL have port press_o, output, NUM_INPUTS: one-cycle pulse on an accepted press.
REQ-010 SHALL have port release_o, output, NUM_INPUTS: one-cycle pulse on an accepted release.
REQ-011 SHALL have port pressed_sticky_o, output, NUM_INPUTS: latched press flag.

Function
REQ-012 SHALL pass each channel through a 2-flop synchroniser after polarity correction; no other logic samples btn_raw_i.
REQ-013 SHALL give each channel a two-state FSM: STABLE (synchronised == btn_o, counter held at 0) and COUNTING (synchronised != btn_o).
REQ-014 SHALL increment the counter by 1 each cycle in COUNTING; the counter is $clog2(DEBOUNCE_CYCLES) bits wide and never wraps.
REQ-015 SHALL clear the counter and return to STABLE without changing btn_o if the synchronised input equals btn_o again before the terminal count (glitch rejection).
REQ-016 SHALL, when the counter equals DEBOUNCE_CYCLES-1 with the mismatch still present, toggle btn_o, clear the counter and enter STABLE, all on the same edge.
REQ-017 SHALL change btn_o on the (2+DEBOUNCE_CYCLES)-th rising edge after a raw change that is held steady; this is the total latency.
REQ-018 SHALL assert press_o (0->1) or release_o (1->0) for exactly one cycle, registered and coincident with the btn_o change.
REQ-019 SHALL set pressed_sticky_o on a press and clear it on a clr_i cycle; on a simultaneous press and clr_i, set wins.
REQ-020 SHALL keep channels fully independent; simultaneous events on several channels are each reported.

Reset
REQ-021 SHALL, on reset, set the synchronisers, btn_o, press_o, release_o and pressed_sticky_o to 0, clear all counters and set every FSM to STABLE.
REQ-022 SHALL, on reset asserted mid-count, abandon the count with no pulse; a button held through reset is accepted DEBOUNCE_CYCLES+2 cycles after release of reset.

Configuration
REQ-023 SHALL compile the sticky press latch only when BTN_DEBOUNCE_STICKY_EN is defined; otherwise pressed_sticky_o is constant 0, clr_i is ignored and the latch flops are absent.

Structure
REQ-024 SHALL place in shared package btn_debounce_pkg the FSM state typedef (STABLE, COUNTING) and the constant SYNC_STAGES = 2.
REQ-025 SHALL implement one channel (synchroniser, counter, FSM, pulse, sticky) in sub-module debounce_cell, instantiated NUM_INPUTS times by generate.

Verification (DEBOUNCE_CYCLES=4, ACTIVE_LOW=1, NUM_INPUTS=2)
REQ-026 Bench SHALL drive btn_raw_i[0] from 1 to 0 and hold it; btn_o[0] SHALL rise on the 6th edge, press_o[0] SHALL be high for one cycle, and pressed_sticky_o[0]=1.
REQ-027 Bench SHALL drive a 3-cycle low glitch on btn_raw_i[1]; btn_o[1], press_o[1] and release_o[1] SHALL stay 0.
REQ-028 Bench SHALL release the pressed button (0->1 held); btn_o[0] SHALL fall 6 edges later with a single release_o[0] pulse, and pressed_sticky_o[0] SHALL remain 1.
REQ-029 Bench SHALL pulse clr_i[0] on the same cycle as a new accepted press; pressed_sticky_o[0] SHALL be 1 afterwards, and a later clr_i[0] alone SHALL clear it.
REQ-030 Bench SHALL assert reset for 1 cycle after 3 cycles of COUNTING; there SHALL be no pulse, all outputs SHALL be 0, and with the button held, btn_o SHALL rise 6 edges after reset deasserts.
REQ-031 Bench SHALL press both channels on the same cycle; both press_o bits SHALL pulse on the same edge.

Source files
------------

// File: rtl/btn_debounce_pkg.sv
// Shared types and constants for the btn_debounce block.
package btn_debounce_pkg;

  typedef enum logic {
    STABLE   = 1'b0,
    COUNTING = 1'b1
  } state_e;

  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/debounce_cell.sv
// One debounce channel: polarity fix, synchroniser, stability counter, FSM, pulses.
// Sticky press latch is present only when BTN_DEBOUNCE_STICKY_EN is defined.
module debounce_cell
  import btn_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  input  logic clr_i,
  output logic btn_o,
  output logic press_o,
  output logic release_o,
  output logic sticky_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic                   pol_s;
  logic                   mismatch_s;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   btn_q, btn_d;
  logic                   press_q, press_d;
  logic                   release_q, release_d;

  assign pol_s = ACTIVE_LOW ? ~raw_i : raw_i;

  // Next-state logic: a change is accepted only after DEBOUNCE_CYCLES mismatching samples.
  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], pol_s};
    mismatch_s = sync_q[SYNC_STAGES-1] ^ btn_q;
    state_d    = state_q;
    cnt_d      = cnt_q;
    btn_d      = btn_q;
    press_d    = 1'b0;
    release_d  = 1'b0;
    case (state_q)
      STABLE: begin
        if (mismatch_s) begin
          state_d = COUNTING;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d = '0;
        end
      end
      COUNTING: begin
        if (!mismatch_s) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = STABLE;
          cnt_d     = '0;
          btn_d     = ~btn_q;
          press_d   = ~btn_q;
          release_d = btn_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Channel state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q    <= '0;
      state_q   <= STABLE;
      cnt_q     <= '0;
      btn_q     <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      btn_q     <= btn_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign btn_o     = btn_q;
  assign press_o   = press_q;
  assign release_o = release_q;

`ifdef BTN_DEBOUNCE_STICKY_EN
  logic sticky_q, sticky_d;

  // Set has priority over clear so a press coinciding with clr_i is never lost.
  always_comb begin
    if (press_d) begin
      sticky_d = 1'b1;
    end else if (clr_i) begin
      sticky_d = 1'b0;
    end else begin
      sticky_d = sticky_q;
    end
  end

  // Sticky flag register.
  always_ff @(posedge clk) begin
    if (reset) begin
      sticky_q <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign sticky_o = sticky_q;
`else
  logic unused_clr_s;
  assign unused_clr_s = clr_i;
  assign sticky_o     = 1'b0;
`endif

endmodule

// File: rtl/btn_debounce.sv
// Multi-channel button debouncer; one debounce_cell per input.
// Optional sticky press latch enabled by defining BTN_DEBOUNCE_STICKY_EN.
module btn_debounce
  import btn_debounce_pkg::*;
#(
  parameter int NUM_INPUTS      = 2,
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_INPUTS-1:0] btn_raw_i,
  input  logic [NUM_INPUTS-1:0] clr_i,
  output logic [NUM_INPUTS-1:0] btn_o,
  output logic [NUM_INPUTS-1:0] press_o,
  output logic [NUM_INPUTS-1:0] release_o,
  output logic [NUM_INPUTS-1:0] pressed_sticky_o
);

  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_ch
    debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW)
    ) u_cell (
      .clk      (clk),
      .reset    (reset),
      .raw_i    (btn_raw_i[i]),
      .clr_i    (clr_i[i]),
      .btn_o    (btn_o[i]),
      .press_o  (press_o[i]),
      .release_o(release_o[i]),
      .sticky_o (pressed_sticky_o[i])
    );
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Self-checking bench for btn_debounce: directed scenarios plus random stimulus
// compared every cycle against a run-length reference model.
module tb_btn_debounce;

  localparam int DEB = 4;
`ifdef BTN_DEBOUNCE_STICKY_EN
  localparam logic STICKY_EN = 1'b1;
`else
  localparam logic STICKY_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] btn_raw_i, clr_i;
  logic [1:0] btn_o, press_o, release_o, pressed_sticky_o;

  btn_debounce #(.NUM_INPUTS(2), .DEBOUNCE_CYCLES(DEB), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .reset(reset), .btn_raw_i(btn_raw_i), .clr_i(clr_i),
    .btn_o(btn_o), .press_o(press_o), .release_o(release_o),
    .pressed_sticky_o(pressed_sticky_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: pressed level seen through a 2-sample delay line; the
  // output flips once DEB consecutive delayed samples disagree with it.
  logic [1:0] d1_m = 2'b00, d2_m = 2'b00;
  logic [1:0] btn_m = 2'b00, press_m = 2'b00, rel_m = 2'b00, sticky_m = 2'b00;
  int         run_m [2] = '{0, 0};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    for (int c = 0; c < 2; c++) begin
      if (reset) begin
        d1_m[c] = 1'b0; d2_m[c] = 1'b0; btn_m[c] = 1'b0;
        press_m[c] = 1'b0; rel_m[c] = 1'b0; sticky_m[c] = 1'b0; run_m[c] = 0;
      end else begin
        press_m[c] = 1'b0;
        rel_m[c]   = 1'b0;
        if (d2_m[c] != btn_m[c]) run_m[c]++;
        else run_m[c] = 0;
        if (run_m[c] == DEB) begin
          btn_m[c]   = ~btn_m[c];
          press_m[c] = btn_m[c];
          rel_m[c]   = ~btn_m[c];
          run_m[c]   = 0;
        end
        if (STICKY_EN) begin
          if (press_m[c]) sticky_m[c] = 1'b1;
          else if (clr_i[c]) sticky_m[c] = 1'b0;
        end
        d2_m[c] = d1_m[c];
        d1_m[c] = ~btn_raw_i[c];
      end
    end
    #1;
    check_eq("btn", 32'(btn_o), 32'(btn_m));
    check_eq("press", 32'(press_o), 32'(press_m));
    check_eq("release", 32'(release_o), 32'(rel_m));
    check_eq("sticky", 32'(pressed_sticky_o), 32'(sticky_m));
  endtask

  // Steps until btn_o[ch] reaches target; returns the edge index (0 = never within budget).
  task automatic wait_btn(input int ch, input logic target, output int lat,
                          output int n_press, output int n_rel);
    lat = 0; n_press = 0; n_rel = 0;
    for (int e = 1; e <= 12; e++) begin
      step();
      if (btn_o[ch] === target && lat == 0) lat = e;
      if (press_o[ch]) n_press++;
      if (release_o[ch]) n_rel++;
    end
  endtask

  initial begin
    int lat, np, nr, hold;
    logic [1:0] glitch_acc;

    reset = 1'b1; btn_raw_i = 2'b11; clr_i = 2'b00;
    step(); step();
    check_eq("rst_btn", 32'(btn_o), 32'd0);
    check_eq("rst_sticky", 32'(pressed_sticky_o), 32'd0);
    reset = 1'b0;
    step();

    // Press channel 0 and hold.
    btn_raw_i[0] = 1'b0;
    wait_btn(0, 1'b1, lat, np, nr);
    check_eq("press_lat", 32'(lat), 32'd6);
    check_eq("press_cnt", 32'(np), 32'd1);
    check_eq("press_sticky", 32'(pressed_sticky_o[0]), 32'(STICKY_EN));

    // Three-cycle glitch on channel 1 must be rejected.
    glitch_acc = 2'b00;
    btn_raw_i[1] = 1'b0;
    for (int i = 0; i < 3; i++) begin step(); glitch_acc |= {btn_o[1] | press_o[1], release_o[1]}; end
    btn_raw_i[1] = 1'b1;
    for (int i = 0; i < 10; i++) begin step(); glitch_acc |= {btn_o[1] | press_o[1], release_o[1]}; end
    check_eq("glitch", 32'(glitch_acc), 32'd0);

    // Release channel 0.
    btn_raw_i[0] = 1'b1;
    wait_btn(0, 1'b0, lat, np, nr);
    check_eq("rel_lat", 32'(lat), 32'd6);
    check_eq("rel_cnt", 32'(nr), 32'd1);
    check_eq("rel_sticky", 32'(pressed_sticky_o[0]), 32'(STICKY_EN));

    // clr_i coincident with an accepted press: set wins.
    btn_raw_i[0] = 1'b0;
    for (int i = 0; i < 5; i++) step();
    clr_i[0] = 1'b1;
    step();
    clr_i[0] = 1'b0;
    check_eq("clr_press_pulse", 32'(press_o[0]), 32'd1);
    check_eq("clr_press_sticky", 32'(pressed_sticky_o[0]), 32'(STICKY_EN));
    step();
    clr_i[0] = 1'b1;
    step();
    clr_i[0] = 1'b0;
    check_eq("clr_alone", 32'(pressed_sticky_o[0]), 32'd0);

    // Release, then reset after three cycles of counting on a new press.
    btn_raw_i[0] = 1'b1;
    for (int i = 0; i < 8; i++) step();
    btn_raw_i[0] = 1'b0;
    for (int i = 0; i < 5; i++) step();
    reset = 1'b1;
    step();
    check_eq("midrst_btn", 32'(btn_o), 32'd0);
    check_eq("midrst_pulse", 32'({press_o, release_o}), 32'd0);
    check_eq("midrst_sticky", 32'(pressed_sticky_o), 32'd0);
    reset = 1'b0;
    wait_btn(0, 1'b1, lat, np, nr);
    check_eq("postrst_lat", 32'(lat), 32'd6);

    // Simultaneous press on both channels.
    btn_raw_i = 2'b11;
    for (int i = 0; i < 8; i++) step();
    btn_raw_i = 2'b00;
    lat = 0;
    for (int e = 1; e <= 12; e++) begin
      step();
      if (press_o != 2'b00 && lat == 0) begin
        lat = e;
        check_eq("both_press", 32'(press_o), 32'd3);
      end
    end
    check_eq("both_lat", 32'(lat), 32'd6);

    // Random phase: held levels of random length, random clears, occasional reset.
    hold = 0;
    for (int i = 0; i < 600; i++) begin
      if (hold == 0) begin
        btn_raw_i = 2'($urandom_range(0, 3));
        hold = $urandom_range(1, 9);
      end
      hold--;
      clr_i = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      reset = ($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
